drive_sequencer: RTL and testbench

DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

---
 rtl/drive_sequencer.sv | 146 ++++++++++++++
 tb/tb_drive_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// Line-following drive sequencer: synchronizes and debounces two line sensors,
// selects a drive mode, and slews two servo pulse codes toward mode targets once per frame.
module drive_sequencer #(
    parameter int unsigned NEUTRAL     = 130,
    parameter int unsigned FWD_DELTA   = 20,
    parameter int unsigned SRCH_DELTA  = 10,
    parameter int unsigned STEP        = 4,
    parameter int unsigned DEB_CYC     = 4,
    parameter int unsigned LOST_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sensor,
    input  logic       enable,
    input  logic       frame_tick,
    output logic [9:0] servo_L,
    output logic [9:0] servo_R,
    output logic [2:0] drive_state,
    output logic       upd
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FORWARD    = 3'd1,
        TURN_LEFT  = 3'd2,
        TURN_RIGHT = 3'd3,
        SEARCH     = 3'd4
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam int unsigned DW = $clog2(DEB_CYC + 1);
    localparam int unsigned LW = $clog2(LOST_FRAMES + 1);

    localparam logic [9:0] CODE_N      = 10'(NEUTRAL);
    localparam logic [9:0] CODE_FWD_HI = 10'(NEUTRAL + FWD_DELTA);
    localparam logic [9:0] CODE_FWD_LO = 10'(NEUTRAL - FWD_DELTA);
    localparam logic [9:0] CODE_SRC_HI = 10'(NEUTRAL + SRCH_DELTA);
    localparam logic [9:0] CODE_SRC_LO = 10'(NEUTRAL - SRCH_DELTA);

    logic [1:0]    sync1, sync2, deb;
    logic [DW-1:0] deb_cnt;
    logic [LW-1:0] lost_cnt;
    state_t        state, state_nxt;
    dir_t          last_dir;
    logic [9:0]    tgt_l, tgt_r;

    // Move cur toward tgt by at most STEP; the 11-bit difference keeps the sign
    // so neither direction can overshoot or wrap.
    function automatic logic [9:0] slew(input logic [9:0] cur, input logic [9:0] tgt);
        logic [10:0] diff;
        logic [10:0] mag;
        diff = {1'b0, tgt} - {1'b0, cur};
        mag  = diff[10] ? (~diff + 11'd1) : diff;
        if (mag <= 11'(STEP))
            return tgt;
        else if (diff[10])
            return cur - 10'(STEP);
        else
            return cur + 10'(STEP);
    endfunction

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (deb)
                2'b11:   state_nxt = FORWARD;
                2'b01:   state_nxt = TURN_LEFT;
                2'b10:   state_nxt = TURN_RIGHT;
                default: begin
                    if (state == IDLE || lost_cnt >= LW'(LOST_FRAMES))
                        state_nxt = SEARCH;
                end
            endcase
        end
    end

    always_comb begin
        tgt_l = CODE_N;
        tgt_r = CODE_N;
        case (state)
            FORWARD:    begin tgt_l = CODE_FWD_HI; tgt_r = CODE_FWD_LO; end
            TURN_LEFT:  begin tgt_l = CODE_N;      tgt_r = CODE_FWD_LO; end
            TURN_RIGHT: begin tgt_l = CODE_FWD_HI; tgt_r = CODE_N;      end
            SEARCH: begin
                if (last_dir == DIR_LEFT) begin
                    tgt_l = CODE_SRC_LO; tgt_r = CODE_SRC_LO;
                end else begin
                    tgt_l = CODE_SRC_HI; tgt_r = CODE_SRC_HI;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_cnt  <= '0;
            lost_cnt <= '0;
            state    <= IDLE;
            last_dir <= DIR_LEFT;
            servo_L  <= CODE_N;
            servo_R  <= CODE_N;
            upd      <= 1'b0;
        end else begin
            sync1 <= sensor;
            sync2 <= sync1;

            // sync1 is the value sync2 takes next, so a mismatch means a change is arriving.
            if (sync1 != sync2)
                deb_cnt <= '0;
            else if (deb_cnt == DW'(DEB_CYC - 1))
                deb <= sync2;
            else
                deb_cnt <= deb_cnt + 1'b1;

            if (state == IDLE || deb != 2'b00)
                lost_cnt <= '0;
            else if (frame_tick && lost_cnt < LW'(LOST_FRAMES))
                lost_cnt <= lost_cnt + 1'b1;

            state <= state_nxt;
            if (state_nxt == TURN_LEFT)
                last_dir <= DIR_LEFT;
            else if (state_nxt == TURN_RIGHT)
                last_dir <= DIR_RIGHT;

            if (frame_tick) begin
                servo_L <= slew(servo_L, tgt_l);
                servo_R <= slew(servo_R, tgt_r);
            end
            upd <= frame_tick;
        end
    end

    assign drive_state = state;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer: power-up, debounce, line loss, enable drop,
// reset mid-slew, and a bounded random sweep checking outputs stay in range.
module tb_drive_sequencer;

    localparam int unsigned N    = 130;
    localparam int unsigned FWD  = 20;
    localparam int unsigned SRCH = 10;
    localparam int unsigned MX   = (FWD > SRCH) ? FWD : SRCH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sensor = 2'b00;
    logic       enable = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] servo_L, servo_R;
    logic [2:0] drive_state;
    logic       upd;

    int errors = 0;
    int checks = 0;

    drive_sequencer #(
        .NEUTRAL(N), .FWD_DELTA(FWD), .SRCH_DELTA(SRCH),
        .STEP(4), .DEB_CYC(4), .LOST_FRAMES(3)
    ) dut (
        .clk(clk), .rst(rst), .sensor(sensor), .enable(enable),
        .frame_tick(frame_tick), .servo_L(servo_L), .servo_R(servo_R),
        .drive_state(drive_state), .upd(upd)
    );

    always #5 clk = ~clk;

    task automatic clocks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One frame tick; returns at the negedge right after the tick edge.
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clocks(2);
        checks++;
        if (servo_L !== 10'd130 || servo_R !== 10'd130 || drive_state !== 3'd0 || upd !== 1'b0) begin
            errors++;
            $display("FAIL reset: got L=%0d R=%0d st=%0d upd=%0b, want 130 130 0 0",
                     servo_L, servo_R, drive_state, upd);
        end
        rst = 1'b0;
    endtask

    task automatic test_powerup();
        int exp_l[6] = '{134, 138, 142, 146, 150, 150};
        int exp_r[6] = '{126, 122, 118, 114, 110, 110};
        enable = 1'b1;
        sensor = 2'b11;
        clocks(10);
        checks++;
        if (drive_state !== 3'd1) begin
            errors++;
            $display("FAIL powerup_state: got %0d want 1", drive_state);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (servo_L !== 10'(exp_l[i]) || servo_R !== 10'(exp_r[i]) || upd !== 1'b1) begin
                errors++;
                $display("FAIL powerup_slew[%0d]: got L=%0d R=%0d upd=%0b, want %0d %0d 1",
                         i, servo_L, servo_R, upd, exp_l[i], exp_r[i]);
            end
        end
        clocks(1);
        checks++;
        if (upd !== 1'b0) begin
            errors++;
            $display("FAIL upd_idle: got %0b want 0", upd);
        end
    endtask

    task automatic test_debounce();
        int exp_l[5] = '{146, 142, 138, 134, 130};
        sensor = 2'b01;
        clocks(3);
        sensor = 2'b11;
        clocks(10);
        checks++;
        if (drive_state !== 3'd1) begin
            errors++;
            $display("FAIL glitch_rejected: got state %0d want 1", drive_state);
        end
        sensor = 2'b01;
        clocks(8);
        checks++;
        if (drive_state !== 3'd2) begin
            errors++;
            $display("FAIL turn_left: got state %0d want 2", drive_state);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (servo_L !== 10'(exp_l[i]) || servo_R !== 10'd110) begin
                errors++;
                $display("FAIL turn_left_slew[%0d]: got L=%0d R=%0d want %0d 110",
                         i, servo_L, servo_R, exp_l[i]);
            end
        end
    endtask

    task automatic test_line_loss();
        int n;
        sensor = 2'b10;
        clocks(8);
        checks++;
        if (drive_state !== 3'd3) begin
            errors++;
            $display("FAIL turn_right: got state %0d want 3", drive_state);
        end
        sensor = 2'b00;
        clocks(10);
        tick();
        tick();
        clocks(3);
        checks++;
        if (drive_state !== 3'd3) begin
            errors++;
            $display("FAIL lost_hold: got state %0d want 3 after two ticks", drive_state);
        end
        tick();
        checks++;
        if (servo_L !== 10'd142 || servo_R !== 10'd122) begin
            errors++;
            $display("FAIL turn_right_slew: got L=%0d R=%0d want 142 122", servo_L, servo_R);
        end
        clocks(1);
        checks++;
        if (drive_state !== 3'd4) begin
            errors++;
            $display("FAIL search_entry: got state %0d want 4", drive_state);
        end
        tick();
        checks++;
        if (servo_L !== 10'd140 || servo_R !== 10'd126) begin
            errors++;
            $display("FAIL search_slew: got L=%0d R=%0d want 140 126", servo_L, servo_R);
        end
        sensor = 2'b11;
        n = 0;
        while (drive_state !== 3'd1 && n < 7) begin
            clocks(1);
            n++;
        end
        checks++;
        if (drive_state !== 3'd1) begin
            errors++;
            $display("FAIL search_exit: got state %0d want 1 within 7 clocks", drive_state);
        end
    endtask

    task automatic test_enable_drop();
        int exp_l[5] = '{146, 142, 138, 134, 130};
        int exp_r[5] = '{114, 118, 122, 126, 130};
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (servo_L !== 10'd150 || servo_R !== 10'd110) begin
            errors++;
            $display("FAIL fwd_settle: got L=%0d R=%0d want 150 110", servo_L, servo_R);
        end
        enable = 1'b0;
        clocks(1);
        checks++;
        if (drive_state !== 3'd0 || servo_L !== 10'd150) begin
            errors++;
            $display("FAIL disable_idle: got state %0d L=%0d want 0 150", drive_state, servo_L);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (servo_L !== 10'(exp_l[i]) || servo_R !== 10'(exp_r[i]) || upd !== 1'b1) begin
                errors++;
                $display("FAIL disable_slew[%0d]: got L=%0d R=%0d upd=%0b want %0d %0d 1",
                         i, servo_L, servo_R, upd, exp_l[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_reset_mid_slew();
        enable = 1'b1;
        clocks(2);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (servo_L !== 10'd142 || servo_R !== 10'd118) begin
            errors++;
            $display("FAIL preslew: got L=%0d R=%0d want 142 118", servo_L, servo_R);
        end
        @(negedge clk);
        rst = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame_tick = 1'b0;
        checks++;
        if (servo_L !== 10'd130 || servo_R !== 10'd130 || drive_state !== 3'd0 || upd !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_slew: got L=%0d R=%0d st=%0d upd=%0b want 130 130 0 0",
                     servo_L, servo_R, drive_state, upd);
        end
    endtask

    task automatic test_random_bounds();
        logic prev_tick;
        prev_tick = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            checks++;
            if (servo_L < 10'(N - MX) || servo_L > 10'(N + MX) ||
                servo_R < 10'(N - MX) || servo_R > 10'(N + MX) || upd !== prev_tick) begin
                errors++;
                $display("FAIL random_bounds[%0d]: got L=%0d R=%0d upd=%0b want in [%0d,%0d] upd=%0b",
                         i, servo_L, servo_R, upd, N - MX, N + MX, prev_tick);
            end
            if ((i % 17) == 0) sensor = 2'($urandom_range(0, 3));
            enable     = ($urandom_range(0, 15) != 0);
            frame_tick = ($urandom_range(0, 3) == 0);
            prev_tick  = frame_tick;
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        if (!(N >= MX && N + MX <= 1023)) begin
            $display("FAIL params: NEUTRAL=%0d with max delta %0d is out of range", N, MX);
            $fatal(1, "illegal parameter set");
        end
        test_reset();
        test_powerup();
        test_debounce();
        test_line_loss();
        test_enable_drop();
        test_reset_mid_slew();
        test_random_bounds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
